// File: rtl/peak_find_if.sv
// peak_find_if -- bus between the peak finder, the shared spectrum memory
// and the top-level controller.
//
//   addr        : read address into the spectrum memory (peak finder drives)
//   data_in     : memory read data, valid one cycle after addr
//   do_peak     : level request from the controller, held until peak_done
//   peak_done   : scan complete, held while do_peak stays high
//   peak_bin    : index of the largest-magnitude bin
//   peak_mag    : magnitude at peak_bin
//   peak_valid  : peak_mag reached the reporting threshold
//
// Modports: slave = peak finder side, master = controller/memory side.
interface peak_find_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              do_peak;
  logic              peak_done;
  logic [ADDR_W-1:0] peak_bin;
  logic [DATA_W-1:0] peak_mag;
  logic              peak_valid;

  modport slave (
    input  data_in,
    input  do_peak,
    output addr,
    output peak_done,
    output peak_bin,
    output peak_mag,
    output peak_valid
  );

  modport master (
    output data_in,
    output do_peak,
    input  addr,
    input  peak_done,
    input  peak_bin,
    input  peak_mag,
    input  peak_valid
  );
endinterface

// File: rtl/peak_find.sv
// peak_find -- scans bins FIRST_BIN..LAST_BIN of the spectrum memory and
// reports the largest magnitude and its bin. Read-only access to memory.
//
// Ports:
//   clk    : single clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   bus    : peak_find_if.slave (addr, data_in, do_peak, peak_done,
//            peak_bin, peak_mag, peak_valid)
//
// Timing: the edge that samples do_peak=1 in IDLE issues FIRST_BIN; one
// address per cycle follows. Memory data for the address issued at cycle t
// arrives at cycle t+1 and is compared then against the running max, with
// tag_p0 carrying the matching address. DRAIN waits for that compare stage
// to empty, so peak_done rises N+2 edges after the request edge.
module peak_find #(
  parameter int FIRST_BIN = 1,
  parameter int LAST_BIN  = 1023,
  parameter int MIN_MAG   = 64,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  peak_find_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_BIN);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_BIN);
  localparam logic [DATA_W-1:0] MIN_M   = DATA_W'(MIN_MAG);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_r;

  // address whose data is on data_in this cycle
  logic [ADDR_W-1:0] tag_p0;
  logic              vld_p0;

  // running max and its bin
  logic [DATA_W-1:0] max_p1;
  logic [ADDR_W-1:0] bin_p1;

  logic [DATA_W-1:0] max_nxt;
  logic [ADDR_W-1:0] bin_nxt;

  logic              done_r;
  logic [ADDR_W-1:0] peak_bin_r;
  logic [DATA_W-1:0] peak_mag_r;
  logic              peak_valid_r;

  // Strictly greater only: bins arrive in ascending order, so an equal
  // magnitude later in the scan never displaces the first occurrence.
  function automatic logic mag_wins(input logic [DATA_W-1:0] cand,
                                    input logic [DATA_W-1:0] best);
    return cand > best;
  endfunction

  function automatic logic above_floor(input logic [DATA_W-1:0] mag);
    return mag >= MIN_M;
  endfunction

  // compare stage: data_in against the running max
  always_comb begin
    max_nxt = max_p1;
    bin_nxt = bin_p1;
    if (vld_p0 && mag_wins(bus.data_in, max_p1)) begin
      max_nxt = bus.data_in;
      bin_nxt = tag_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_r       <= '0;
      tag_p0       <= '0;
      vld_p0       <= 1'b0;
      max_p1       <= '0;
      bin_p1       <= '0;
      done_r       <= 1'b0;
      peak_bin_r   <= '0;
      peak_mag_r   <= '0;
      peak_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          vld_p0 <= 1'b0;
          addr_r <= '0;
          if (bus.do_peak) begin
            state  <= S_SCAN;
            addr_r <= FIRST_A;
            max_p1 <= '0;
            // an all-zero spectrum then reports FIRST_BIN
            bin_p1 <= FIRST_A;
          end
        end

        S_SCAN: begin
          if (!bus.do_peak) begin
            state  <= S_IDLE;
            addr_r <= '0;
            vld_p0 <= 1'b0;
          end else begin
            tag_p0 <= addr_r;
            vld_p0 <= 1'b1;
            max_p1 <= max_nxt;
            bin_p1 <= bin_nxt;
            // addr stops at LAST_BIN and is held there through DONE
            if (addr_r == LAST_A) begin
              state <= S_DRAIN;
            end else begin
              addr_r <= addr_r + ADDR_W'(1);
            end
          end
        end

        S_DRAIN: begin
          if (!bus.do_peak) begin
            state  <= S_IDLE;
            addr_r <= '0;
            vld_p0 <= 1'b0;
          end else begin
            max_p1 <= max_nxt;
            bin_p1 <= bin_nxt;
            vld_p0 <= 1'b0;
            // once the LAST_BIN sample has been folded in, publish
            if (!vld_p0) begin
              state        <= S_DONE;
              done_r       <= 1'b1;
              peak_bin_r   <= bin_p1;
              peak_mag_r   <= max_p1;
              peak_valid_r <= above_floor(max_p1);
            end
          end
        end

        S_DONE: begin
          if (!bus.do_peak) begin
            state  <= S_IDLE;
            addr_r <= '0;
            done_r <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          addr_r <= '0;
          vld_p0 <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr       = addr_r;
  assign bus.peak_done  = done_r;
  assign bus.peak_bin   = peak_bin_r;
  assign bus.peak_mag   = peak_mag_r;
  assign bus.peak_valid = peak_valid_r;

endmodule

// File: tb/tb_peak_find.sv
// tb_peak_find -- bench for peak_find: directed spectra plus randomized
// spectra checked against a reference peak computed from the memory image.
module tb_peak_find;

  localparam int FIRST_BIN = 1;
  localparam int LAST_BIN  = 1023;
  localparam int MIN_MAG   = 64;
  localparam int NBINS     = LAST_BIN - FIRST_BIN + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  peak_find_if bus ();

  peak_find #(
    .FIRST_BIN (FIRST_BIN),
    .LAST_BIN  (LAST_BIN),
    .MIN_MAG   (MIN_MAG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // spectrum memory: registered read, data one cycle after addr
  logic [9:0] mem [0:2047];
  always @(posedge clk) bus.data_in <= mem[bus.addr];

  int checks   = 0;
  int failures = 0;

  int  exp_bin, exp_mag, exp_valid;
  bit  addr_oob = 1'b0;

  always @(negedge clk) if (rst_n === 1'b1 && int'(bus.addr) > LAST_BIN) addr_oob = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: largest value in the scanned range, then the lowest bin
  // holding that value.
  task automatic ref_peak();
    int best;
    best = 0;
    for (int i = FIRST_BIN; i <= LAST_BIN; i++)
      if (int'(mem[i]) > best) best = int'(mem[i]);
    exp_mag = best;
    exp_bin = FIRST_BIN;
    for (int i = LAST_BIN; i >= FIRST_BIN; i--)
      if (int'(mem[i]) == best) exp_bin = i;
    exp_valid = (best >= MIN_MAG) ? 1 : 0;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 2048; i++) mem[i] = 10'(v);
  endtask

  // full request/complete/release cycle with latency and result checks
  task automatic run_scan(input string tag);
    int  cnt;
    bit  seen;
    ref_peak();
    @(negedge clk);
    bus.do_peak = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".addr_first"}, 32'(bus.addr), FIRST_BIN);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < NBINS + 50) begin
      @(posedge clk);
      cnt++;
      #1;
      seen = bus.peak_done;
    end
    chk({tag, ".latency"}, cnt, NBINS + 2);
    @(negedge clk);
    chk({tag, ".done"},  32'(bus.peak_done),  1);
    chk({tag, ".bin"},   32'(bus.peak_bin),   exp_bin);
    chk({tag, ".mag"},   32'(bus.peak_mag),   exp_mag);
    chk({tag, ".valid"}, 32'(bus.peak_valid), exp_valid);
    bus.do_peak = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_clr"}, 32'(bus.peak_done), 0);
    chk({tag, ".bin_kept"}, 32'(bus.peak_bin),  exp_bin);
    chk({tag, ".addr_idle"}, 32'(bus.addr),     0);
  endtask

  int r_bin, r_mag, r_valid;
  bit done_seen;

  initial begin
    rst_n       = 1'b0;
    bus.do_peak = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.addr",  32'(bus.addr),       0);
    chk("rst.done",  32'(bus.peak_done),  0);
    chk("rst.bin",   32'(bus.peak_bin),   0);
    chk("rst.mag",   32'(bus.peak_mag),   0);
    chk("rst.valid", 32'(bus.peak_valid), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle.addr", 32'(bus.addr), 0);

    // single spike
    fill(10); mem[100] = 10'd600;
    run_scan("spike");
    chk("spike.bin_abs", 32'(bus.peak_bin), 100);

    // tie: first occurrence wins
    fill(0); mem[50] = 10'd500; mem[200] = 10'd500;
    run_scan("tie");
    chk("tie.bin_abs", 32'(bus.peak_bin), 50);

    // DC excluded, last bin captured
    fill(5); mem[0] = 10'd1023; mem[1023] = 10'd300;
    for (int i = 1024; i < 2048; i++) mem[i] = 10'd1023;
    run_scan("edge");
    chk("edge.bin_abs", 32'(bus.peak_bin), 1023);

    // below threshold
    fill(40); mem[7] = 10'd63;
    run_scan("thresh");

    // exactly at threshold
    fill(40); mem[900] = 10'(MIN_MAG);
    run_scan("at_min");

    // all zero
    fill(0); mem[0] = 10'd999;
    run_scan("zero");

    // abort mid-scan after a completed scan with known results
    fill(3); mem[333] = 10'd777;
    run_scan("pre_abort");
    r_bin = exp_bin; r_mag = exp_mag; r_valid = exp_valid;
    fill(1); mem[20] = 10'd1000;
    @(negedge clk);
    bus.do_peak = 1'b1;
    @(posedge clk);
    done_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.peak_done) done_seen = 1'b1;
    end
    @(negedge clk);
    bus.do_peak = 1'b0;
    @(posedge clk);
    #1;
    chk("abort.addr", 32'(bus.addr), 0);
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (bus.peak_done) done_seen = 1'b1;
    end
    chk("abort.no_done", 32'(done_seen),       0);
    chk("abort.bin",     32'(bus.peak_bin),   r_bin);
    chk("abort.mag",     32'(bus.peak_mag),   r_mag);
    chk("abort.valid",   32'(bus.peak_valid), r_valid);
    run_scan("after_abort");

    // reset mid-scan
    fill(2); mem[640] = 10'd880;
    @(negedge clk);
    bus.do_peak = 1'b1;
    @(posedge clk);
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst.addr",  32'(bus.addr),       0);
    chk("mrst.done",  32'(bus.peak_done),  0);
    chk("mrst.bin",   32'(bus.peak_bin),   0);
    chk("mrst.mag",   32'(bus.peak_mag),   0);
    chk("mrst.valid", 32'(bus.peak_valid), 0);
    @(negedge clk);
    bus.do_peak = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mrst.idle_addr", 32'(bus.addr), 0);
    run_scan("after_rst");

    // randomized spectra; DC and the unscanned half hold large values
    for (int t = 0; t < 5; t++) begin
      int lim;
      int sv;
      int ns;
      lim = (t % 2 == 0) ? 60 : 1023;
      for (int i = 0; i < 2048; i++) mem[i] = 10'($urandom_range(0, lim));
      if (t >= 2) begin
        sv = $urandom_range(70, 1020);
        ns = $urandom_range(2, 4);
        for (int k = 0; k < ns; k++) mem[$urandom_range(FIRST_BIN, LAST_BIN)] = 10'(sv);
      end
      mem[0] = 10'd1023;
      for (int i = LAST_BIN + 1; i < 2048; i++) mem[i] = 10'd1023;
      run_scan($sformatf("rand%0d", t));
    end

    chk("addr_range", 32'(addr_oob), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time bound
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
